if_id_hazard_stage: RTL and testbench

- Pipeline stage between IF and ID. Holds the IF/ID register (PC, instruction, valid).
- Detects the data hazards that ID-stage operand forwarding cannot resolve and generates the PC/IF-ID hold and ID/EX bubble controls.
- Squashes the IF/ID register on a taken branch/jump resolved in ID.
- Keeps stall/flush performance counters and a sticky stall-watchdog error flag.

---
 rtl/if_id_hazard_stage_pkg.sv | 39 +++
 rtl/if_id_hazard_stage_hazard_detect.sv | 53 +++++
 rtl/if_id_hazard_stage.sv | 159 +++++++++++++++
 tb/tb_if_id_hazard_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_hazard_stage_pkg.sv
// Shared definitions for the IF/ID stage and its hazard detector.
// Holds the decoder control encodings (branch class, jump class, register
// write-back source), the NOP instruction word, the bundle describing an
// in-flight producer in EX or MEM, and a source/destination match helper.
package if_id_hazard_stage_pkg;

    // Branch class from the decoder; anything other than BRANCH_NONE
    // compares its operands in ID.
    localparam logic [1:0] BRANCH_NONE = 2'b00;
    localparam logic [1:0] BRANCH_BEQ  = 2'b01;
    localparam logic [1:0] BRANCH_BNE  = 2'b10;

    // Jump class; only JUMP_REG (jr/jalr) reads a register in ID.
    localparam logic [1:0] JUMP_NONE   = 2'b00;
    localparam logic [1:0] JUMP_J      = 2'b01;
    localparam logic [1:0] JUMP_REG    = 2'b10;

    // Write-back source of a producing instruction.
    localparam logic [1:0] REGSRC_ALU     = 2'b00;
    localparam logic [1:0] REGSRC_DMEM    = 2'b01;
    localparam logic [1:0] REGSRC_PCPLUS4 = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Register-writing instruction sitting in a later pipeline stage.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] reg_src;
        logic [4:0] write_reg;
    } producer_t;

    // A used, non-$0 source that names the producer's destination.
    function automatic logic src_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/if_id_hazard_stage_hazard_detect.sv
// Combinational hazard detector for the instruction in ID.
// Ports:
//   id_valid          - ID holds a real instruction
//   id_rs, id_rt      - source register fields of the ID instruction
//   use_rs, use_rt    - decoder flags: the source is actually read
//   id_branch/id_jump - decoder branch and jump classes
//   ex_prod, mem_prod - producers currently in EX and MEM
//   stall             - hazard the ID forwarding network cannot cover
module if_id_hazard_stage_hazard_detect
    import if_id_hazard_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [1:0] id_branch,
    input  logic [1:0] id_jump,
    input  producer_t  ex_prod,
    input  producer_t  mem_prod,
    output logic       stall
);

    logic use_at_id;
    logic ex_hit;
    logic mem_hit;
    logic ex_load;
    logic ex_value;
    logic mem_load;

    // A load result is only available after MEM, so any EX-stage load
    // consumer waits; operands compared in ID additionally cannot take an
    // ALU result still in EX or a load result still in MEM. PC+4 producers
    // have their value early and are always forwarded.
    always_comb begin
        use_at_id = (id_branch != BRANCH_NONE) || (id_jump == JUMP_REG);

        ex_hit  = src_match(use_rs, id_rs, ex_prod.write_reg)
               || src_match(use_rt, id_rt, ex_prod.write_reg);
        mem_hit = src_match(use_rs, id_rs, mem_prod.write_reg)
               || src_match(use_rt, id_rt, mem_prod.write_reg);

        ex_load  = ex_prod.reg_write && (ex_prod.reg_src == REGSRC_DMEM);
        ex_value = ex_prod.reg_write && ((ex_prod.reg_src == REGSRC_ALU)
                                      || (ex_prod.reg_src == REGSRC_DMEM));
        mem_load = mem_prod.reg_write && (mem_prod.reg_src == REGSRC_DMEM);

        stall = id_valid && ((ex_load && ex_hit)
                          || (use_at_id && ex_value && ex_hit)
                          || (use_at_id && mem_load && mem_hit));
    end

endmodule

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with hazard stall, branch squash, performance
// counters and a consecutive-stall watchdog.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   IF_PC, IF_instr           - fetched PC and instruction
//   ID_useRs/Rt, ID_Branch,
//   ID_Jump, ID_redirect      - decoder information for the ID instruction
//   EX_*, MEM_*               - producers in EX and MEM
//   ID_PC, ID_instr, ID_valid - IF/ID register contents
//   ID_rs, ID_rt              - source fields of ID_instr
//   PC_write, EX_bubble       - PC enable and ID/EX NOP insertion
//   redirect_ok               - redirect qualified by the absence of a stall
//   stall_cnt, flush_cnt      - saturating stall / squash counters
//   hazard_err                - sticky: stall run longer than MAX_STALL
module if_id_hazard_stage
    import if_id_hazard_stage_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 2
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      IF_PC,
    input  logic [31:0]      IF_instr,
    input  logic             ID_useRs,
    input  logic             ID_useRt,
    input  logic [1:0]       ID_Branch,
    input  logic [1:0]       ID_Jump,
    input  logic             ID_redirect,
    input  logic             EX_RegWrite,
    input  logic [1:0]       EX_RegSrc,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_RegWrite,
    input  logic [1:0]       MEM_RegSrc,
    input  logic [4:0]       MEM_WriteReg,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_instr,
    output logic             ID_valid,
    output logic [4:0]       ID_rs,
    output logic [4:0]       ID_rt,
    output logic             PC_write,
    output logic             EX_bubble,
    output logic             redirect_ok,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hazard_err
);

    // The run counter only needs to reach MAX_STALL+1 and then sits there.
    localparam int CONSEC_W = $clog2(MAX_STALL + 2);
    localparam logic [CONSEC_W-1:0] CONSEC_SAT = CONSEC_W'(MAX_STALL + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_LIM = CONSEC_W'(MAX_STALL);
    localparam logic [CNT_W-1:0]    CNT_SAT    = '1;

    logic [31:0]         pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic                err_q, err_d;

    logic      stall;
    logic      flush;
    producer_t ex_prod;
    producer_t mem_prod;

    assign ex_prod  = {EX_RegWrite, EX_RegSrc, EX_WriteReg};
    assign mem_prod = {MEM_RegWrite, MEM_RegSrc, MEM_WriteReg};

    if_id_hazard_stage_hazard_detect u_hazard_detect (
        .id_valid  (valid_q),
        .id_rs     (instr_q[25:21]),
        .id_rt     (instr_q[20:16]),
        .use_rs    (ID_useRs),
        .use_rt    (ID_useRt),
        .id_branch (ID_Branch),
        .id_jump   (ID_Jump),
        .ex_prod   (ex_prod),
        .mem_prod  (mem_prod),
        .stall     (stall)
    );

    // A redirect is ignored while stalled: the branch operands are not final.
    assign flush = ID_redirect && !stall;

    // Stall holds the register, a squash keeps the redirect target PC but
    // turns the slot into an invalid NOP, otherwise fetch advances.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (!stall) begin
            pc_d = IF_PC;
            if (flush) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                instr_d = IF_instr;
                valid_d = 1'b1;
            end
        end
    end

    // Saturating event counters and the consecutive-stall watchdog; the
    // error fires on the stall cycle that would make the run exceed the limit.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        consec_d    = '0;
        err_d       = err_q;
        if (stall && (stall_cnt_q != CNT_SAT)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != CNT_SAT)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (stall) begin
            consec_d = (consec_q == CONSEC_SAT) ? consec_q : consec_q + CONSEC_W'(1);
            if (consec_q >= CONSEC_LIM) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= '0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            consec_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            consec_q    <= consec_d;
            err_q       <= err_d;
        end
    end

    assign ID_PC       = pc_q;
    assign ID_instr    = instr_q;
    assign ID_valid    = valid_q;
    assign ID_rs       = instr_q[25:21];
    assign ID_rt       = instr_q[20:16];
    assign PC_write    = !stall;
    assign EX_bubble   = stall;
    assign redirect_ok = flush;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign hazard_err  = err_q;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Self-checking bench for if_id_hazard_stage: directed pipeline scenarios
// followed by randomized cycles, all compared against a behavioural model.
module tb_if_id_hazard_stage;
    import if_id_hazard_stage_pkg::*;

    localparam int CNT_W     = 32;
    localparam int MAX_STALL = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic [31:0]      IF_PC;
    logic [31:0]      IF_instr;
    logic             ID_useRs;
    logic             ID_useRt;
    logic [1:0]       ID_Branch;
    logic [1:0]       ID_Jump;
    logic             ID_redirect;
    logic             EX_RegWrite;
    logic [1:0]       EX_RegSrc;
    logic [4:0]       EX_WriteReg;
    logic             MEM_RegWrite;
    logic [1:0]       MEM_RegSrc;
    logic [4:0]       MEM_WriteReg;
    logic [31:0]      ID_PC;
    logic [31:0]      ID_instr;
    logic             ID_valid;
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             PC_write;
    logic             EX_bubble;
    logic             redirect_ok;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             hazard_err;

    if_id_hazard_stage #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .IF_PC        (IF_PC),
        .IF_instr     (IF_instr),
        .ID_useRs     (ID_useRs),
        .ID_useRt     (ID_useRt),
        .ID_Branch    (ID_Branch),
        .ID_Jump      (ID_Jump),
        .ID_redirect  (ID_redirect),
        .EX_RegWrite  (EX_RegWrite),
        .EX_RegSrc    (EX_RegSrc),
        .EX_WriteReg  (EX_WriteReg),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_RegSrc   (MEM_RegSrc),
        .MEM_WriteReg (MEM_WriteReg),
        .ID_PC        (ID_PC),
        .ID_instr     (ID_instr),
        .ID_valid     (ID_valid),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .PC_write     (PC_write),
        .EX_bubble    (EX_bubble),
        .redirect_ok  (redirect_ok),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .hazard_err   (hazard_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model of what the ID stage should contain.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    longint      m_stalls;
    longint      m_flushes;
    int          m_run;
    logic        m_err;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] instrR(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, 5'd1, 5'd0, 6'h21};
    endfunction

    task automatic modelReset();
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        m_valid   = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
        m_run     = 0;
        m_err     = 1'b0;
    endtask

    task automatic clearInputs();
        IF_PC        = 32'h0;
        IF_instr     = 32'h0;
        ID_useRs     = 1'b0;
        ID_useRt     = 1'b0;
        ID_Branch    = BRANCH_NONE;
        ID_Jump      = JUMP_NONE;
        ID_redirect  = 1'b0;
        EX_RegWrite  = 1'b0;
        EX_RegSrc    = REGSRC_ALU;
        EX_WriteReg  = 5'd0;
        MEM_RegWrite = 1'b0;
        MEM_RegSrc   = REGSRC_ALU;
        MEM_WriteReg = 5'd0;
    endtask

    // Which source registers of the modelled ID instruction are waiting on
    // a value that forwarding cannot yet supply.
    function automatic logic modelStall();
        logic [4:0] srcs[$];
        logic [31:0] ins;
        logic at_id;
        if (!m_valid) return 1'b0;
        ins   = m_instr;
        at_id = (ID_Branch != BRANCH_NONE) || (ID_Jump == JUMP_REG);
        if (ID_useRs && ins[25:21] != 5'd0) srcs.push_back(ins[25:21]);
        if (ID_useRt && ins[20:16] != 5'd0) srcs.push_back(ins[20:16]);
        foreach (srcs[i]) begin
            if (EX_RegWrite && EX_WriteReg == srcs[i]) begin
                if (EX_RegSrc == REGSRC_DMEM) return 1'b1;
                if (at_id && EX_RegSrc == REGSRC_ALU) return 1'b1;
            end
            if (at_id && MEM_RegWrite && MEM_WriteReg == srcs[i]
                && MEM_RegSrc == REGSRC_DMEM) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: check combinational controls, advance the model, check state.
    task automatic applyStimulus(input string tag);
        logic exp_stall;
        logic exp_redir;
        logic [31:0] ins;
        #1;
        exp_stall = modelStall();
        exp_redir = ID_redirect && !exp_stall;
        checkOutput({tag, ".PC_write"}, 32'(PC_write), 32'(!exp_stall));
        checkOutput({tag, ".EX_bubble"}, 32'(EX_bubble), 32'(exp_stall));
        checkOutput({tag, ".redirect_ok"}, 32'(redirect_ok), 32'(exp_redir));
        @(posedge clk);
        if (!exp_stall) begin
            m_pc    = IF_PC;
            m_instr = exp_redir ? 32'h0 : IF_instr;
            m_valid = !exp_redir;
        end
        if (exp_stall && m_stalls < 64'h0000_0000_FFFF_FFFF) m_stalls++;
        if (exp_redir && m_flushes < 64'h0000_0000_FFFF_FFFF) m_flushes++;
        m_run = exp_stall ? m_run + 1 : 0;
        if (m_run > MAX_STALL) m_err = 1'b1;
        #1;
        ins = m_instr;
        checkOutput({tag, ".ID_PC"}, ID_PC, m_pc);
        checkOutput({tag, ".ID_instr"}, ID_instr, m_instr);
        checkOutput({tag, ".ID_valid"}, 32'(ID_valid), 32'(m_valid));
        checkOutput({tag, ".ID_rs"}, 32'(ID_rs), 32'(ins[25:21]));
        checkOutput({tag, ".ID_rt"}, 32'(ID_rt), 32'(ins[20:16]));
        checkOutput({tag, ".stall_cnt"}, stall_cnt, 32'(m_stalls));
        checkOutput({tag, ".flush_cnt"}, flush_cnt, 32'(m_flushes));
        checkOutput({tag, ".hazard_err"}, 32'(hazard_err), 32'(m_err));
    endtask

    // Asynchronous reset: state must clear before any clock edge.
    task automatic doReset(input string tag);
        rstn = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, ".ID_PC"}, ID_PC, 32'h0);
        checkOutput({tag, ".ID_instr"}, ID_instr, 32'h0);
        checkOutput({tag, ".ID_valid"}, 32'(ID_valid), 32'h0);
        checkOutput({tag, ".ID_rs"}, 32'(ID_rs), 32'h0);
        checkOutput({tag, ".stall_cnt"}, stall_cnt, 32'h0);
        checkOutput({tag, ".flush_cnt"}, flush_cnt, 32'h0);
        checkOutput({tag, ".hazard_err"}, 32'(hazard_err), 32'h0);
        checkOutput({tag, ".EX_bubble"}, 32'(EX_bubble), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        clearInputs();
        modelReset();
        #2;
        doReset("reset");

        // add $1,$8,$9 enters ID with nothing in flight.
        IF_PC = 32'h100; IF_instr = instrR(5'd8, 5'd9);
        applyStimulus("load_add");

        // lw $8 in EX, add reads $8 as rs: one load-use stall.
        IF_PC = 32'h104; IF_instr = instrR(5'd9, 5'd0);
        ID_useRs = 1'b1; ID_useRt = 1'b1;
        EX_RegWrite = 1'b1; EX_RegSrc = REGSRC_DMEM; EX_WriteReg = 5'd8;
        #1;
        checkOutput("ld_use.PC_write_const", 32'(PC_write), 32'h0);
        checkOutput("ld_use.EX_bubble_const", 32'(EX_bubble), 32'h1);
        applyStimulus("ld_use");
        checkOutput("ld_use.ID_PC_held", ID_PC, 32'h100);

        // lw moves to MEM; add is not a branch so it proceeds. beq $9,$0 fetched.
        EX_RegWrite = 1'b0;
        MEM_RegWrite = 1'b1; MEM_RegSrc = REGSRC_DMEM; MEM_WriteReg = 5'd8;
        applyStimulus("ld_use_go");
        checkOutput("ld_use_go.stall_cnt_const", stall_cnt, 32'd1);

        // lw $9 in EX, beq $9,$0 in ID: two stall cycles.
        MEM_RegWrite = 1'b0;
        ID_Branch = BRANCH_BEQ;
        EX_RegWrite = 1'b1; EX_RegSrc = REGSRC_DMEM; EX_WriteReg = 5'd9;
        IF_PC = 32'h108; IF_instr = instrR(5'd10, 5'd0);
        applyStimulus("ld_br1");
        EX_RegWrite = 1'b0;
        MEM_RegWrite = 1'b1; MEM_RegSrc = REGSRC_DMEM; MEM_WriteReg = 5'd9;
        applyStimulus("ld_br2");
        MEM_RegWrite = 1'b0;
        applyStimulus("ld_br_go");
        checkOutput("ld_br.stall_cnt_const", stall_cnt, 32'd3);
        checkOutput("ld_br.hazard_err_const", 32'(hazard_err), 32'h0);

        // addu $10 in EX, jr $10 in ID: one stall.
        ID_Branch = BRANCH_NONE; ID_Jump = JUMP_REG; ID_useRt = 1'b0;
        EX_RegWrite = 1'b1; EX_RegSrc = REGSRC_ALU; EX_WriteReg = 5'd10;
        IF_PC = 32'h10C; IF_instr = instrR(5'd31, 5'd0);
        applyStimulus("alu_jr");
        EX_RegWrite = 1'b0;
        MEM_RegWrite = 1'b1; MEM_RegSrc = REGSRC_ALU; MEM_WriteReg = 5'd10;
        applyStimulus("alu_jr_go");
        checkOutput("alu_jr.stall_cnt_const", stall_cnt, 32'd4);

        // jal ($31, PC+4) in EX with jr $31 in ID: forwarded, no stall.
        MEM_RegWrite = 1'b0;
        EX_RegWrite = 1'b1; EX_RegSrc = REGSRC_PCPLUS4; EX_WriteReg = 5'd31;
        IF_PC = 32'h110; IF_instr = instrR(5'd1, 5'd2);
        #1;
        checkOutput("jal_jr.PC_write_const", 32'(PC_write), 32'h1);
        applyStimulus("jal_jr");

        // Taken beq $1,$2 with no hazard: squash.
        EX_RegWrite = 1'b0;
        ID_Jump = JUMP_NONE; ID_Branch = BRANCH_BEQ; ID_useRt = 1'b1;
        ID_redirect = 1'b1;
        IF_PC = 32'h200; IF_instr = instrR(5'd7, 5'd7);
        #1;
        checkOutput("flush.redirect_ok_const", 32'(redirect_ok), 32'h1);
        applyStimulus("flush");
        checkOutput("flush.ID_instr_const", ID_instr, 32'h0);
        checkOutput("flush.ID_valid_const", 32'(ID_valid), 32'h0);
        checkOutput("flush.flush_cnt_const", flush_cnt, 32'd1);

        // Refill ID with a branch reading $5.
        ID_redirect = 1'b0;
        IF_PC = 32'h204; IF_instr = instrR(5'd5, 5'd0);
        applyStimulus("refill");

        // Redirect while a load on $5 is in EX: suppressed, then three
        // consecutive stalls trip the watchdog.
        ID_redirect = 1'b1;
        EX_RegWrite = 1'b1; EX_RegSrc = REGSRC_DMEM; EX_WriteReg = 5'd5;
        IF_PC = 32'h300; IF_instr = instrR(5'd3, 5'd4);
        #1;
        checkOutput("redir_stall.redirect_ok_const", 32'(redirect_ok), 32'h0);
        applyStimulus("redir_stall1");
        checkOutput("redir_stall.flush_cnt_const", flush_cnt, 32'd1);
        applyStimulus("redir_stall2");
        checkOutput("wdog.err_at_2", 32'(hazard_err), 32'h0);
        applyStimulus("redir_stall3");
        checkOutput("wdog.err_at_3", 32'(hazard_err), 32'h1);
        EX_RegWrite = 1'b0; ID_redirect = 1'b0;
        applyStimulus("wdog_release");
        checkOutput("wdog.err_sticky", 32'(hazard_err), 32'h1);

        // Reset while ID holds a valid instruction.
        doReset("reset_mid");
        clearInputs();

        // Randomized cycles with small register numbers so hazards are common.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            IF_instr     = ins;
            IF_PC        = $urandom & 32'hFFFF_FFFC;
            ID_useRs     = 1'($urandom);
            ID_useRt     = 1'($urandom);
            ID_Branch    = 2'($urandom);
            ID_Jump      = 2'($urandom);
            ID_redirect  = ($urandom_range(0, 3) == 0);
            EX_RegWrite  = 1'($urandom);
            EX_RegSrc    = 2'($urandom);
            EX_WriteReg  = 5'($urandom_range(0, 3));
            MEM_RegWrite = 1'($urandom);
            MEM_RegSrc   = 2'($urandom);
            MEM_WriteReg = 5'($urandom_range(0, 3));
            applyStimulus("rand");
            if (i % 80 == 79) begin
                doReset("rand_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
